btle_crc24_seq: RTL and testbench

- Sequencer around one internal crc24_core instance.
- Runs a complete BLE CRC pass per packet: loads the 24-bit init value, streams the PDU bits through the LFSR, then one of two phases:
  - TX mode: serialises the 24 CRC bits out.
  - RX mode: compares the 24 received CRC bits against the computed CRC.
- Sits between the bit-level PDU framer/deframer and the GFSK modulator/demodulator paths.

---
 rtl/btle_crc24_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_btle_crc24_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btle_crc24_seq.sv
// BLE CRC-24 sequencer with its LFSR core.
// crc24_core is the bit-serial LFSR (BLE polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1).
// btle_crc24_seq does one CRC pass per packet: load init, stream PDU bits,
// then either serialise the CRC out (TX) or compare the received CRC (RX).

module crc24_core #(
  parameter int CRC_STATE_BIT_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
  input  logic                           crc_state_init_bit_load,
  input  logic                           data_in,
  input  logic                           data_in_valid,
  output logic [CRC_STATE_BIT_WIDTH-1:0] lfsr_next_o
);
  // Low-order taps of the generator; the x^24 term is the bit shifted out.
  localparam logic [23:0] POLY = 24'h00065B;

  logic [CRC_STATE_BIT_WIDTH-1:0] lfsr_q, lfsr_d;
  logic                           feedback;

  // Next LFSR value: byte-swapped init on load, one Galois step per valid bit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    lfsr_d   = lfsr_q;
    feedback = lfsr_q[CRC_STATE_BIT_WIDTH-1] ^ data_in;
    if (crc_state_init_bit_load) begin
      // Init arrives most-significant byte first; the LFSR holds it byte-reversed.
      lfsr_d = {crc_state_init_bit[7:0], crc_state_init_bit[15:8], crc_state_init_bit[23:16]};
    end else if (data_in_valid) begin
      lfsr_d = {lfsr_q[CRC_STATE_BIT_WIDTH-2:0], 1'b0} ^ (feedback ? POLY : '0);
    end
  end

  // LFSR register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_next_o = lfsr_d;
endmodule

module btle_crc24_seq #(
  parameter int CRC_STATE_BIT_WIDTH = 24,
  parameter int LEN_BIT_WIDTH       = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           mode,
  input  logic [LEN_BIT_WIDTH-1:0]       pdu_len_bits,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
  input  logic                           abort,
  input  logic                           data_in,
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  output logic                           crc_bit_out,
  output logic                           crc_bit_out_valid,
  input  logic                           crc_bit_out_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           crc_ok,
  output logic [CRC_STATE_BIT_WIDTH-1:0] crc_value
);
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DATA, ST_CRC} state_t;

  localparam logic [LEN_BIT_WIDTH-1:0] LEN_ONE  = LEN_BIT_WIDTH'(1);
  localparam logic [LEN_BIT_WIDTH-1:0] CRC_LAST = LEN_BIT_WIDTH'(23);

  state_t                         state_q, state_d;
  logic                           mode_q, mode_d;
  logic [LEN_BIT_WIDTH-1:0]       len_q, len_d;
  logic [CRC_STATE_BIT_WIDTH-1:0] init_q, init_d;
  logic [LEN_BIT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                           mismatch_q, mismatch_d;
  logic                           crc_ok_q, crc_ok_d;
  logic [CRC_STATE_BIT_WIDTH-1:0] crc_value_q, crc_value_d;

  logic                           core_load;
  logic                           core_valid;
  logic [CRC_STATE_BIT_WIDTH-1:0] core_next;
  logic [4:0]                     bit_idx;
  logic                           crc_bit;
  logic                           crc_xfer;
  logic                           bit_mismatch;

  crc24_core #(
    .CRC_STATE_BIT_WIDTH(CRC_STATE_BIT_WIDTH)
  ) u_core (
    .clk                     (clk),
    .rst                     (rst),
    .crc_state_init_bit      (init_q),
    .crc_state_init_bit_load (core_load),
    .data_in                 (data_in),
    .data_in_valid           (core_valid),
    .lfsr_next_o             (core_next)
  );

  // In CRC, the counter walks the snapshot MSB first.
  assign bit_idx = 5'd23 - cnt_q[4:0];
  assign crc_bit = crc_value_q[bit_idx];

  // Next-state and output decode for the packet sequencer.
  always_comb begin
    state_d           = state_q;
    mode_d            = mode_q;
    len_d             = len_q;
    init_d            = init_q;
    cnt_d             = cnt_q;
    mismatch_d        = mismatch_q;
    crc_ok_d          = crc_ok_q;
    crc_value_d       = crc_value_q;
    core_load         = 1'b0;
    core_valid        = 1'b0;
    data_in_ready     = 1'b0;
    crc_bit_out       = 1'b0;
    crc_bit_out_valid = 1'b0;
    done              = 1'b0;
    crc_xfer          = 1'b0;
    bit_mismatch      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d     = mode;
          len_d      = pdu_len_bits;
          init_d     = crc_state_init_bit;
          cnt_d      = '0;
          mismatch_d = 1'b0;
          crc_ok_d   = 1'b0;
          state_d    = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (abort) begin
          crc_ok_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          core_load = 1'b1;
          if (len_q == '0) begin
            // Empty PDU: the CRC is just the freshly loaded LFSR.
            crc_value_d = core_next;
            state_d     = ST_CRC;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        data_in_ready = 1'b1;
        if (abort) begin
          // Abort wins: the offered bit is not passed to the core.
          cnt_d    = '0;
          crc_ok_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (data_in_valid) begin
          core_valid = 1'b1;
          if (cnt_q == len_q - LEN_ONE) begin
            // Last PDU bit: capture the LFSR value it produces.
            crc_value_d = core_next;
            cnt_d       = '0;
            state_d     = ST_CRC;
          end else begin
            cnt_d = cnt_q + LEN_ONE;
          end
        end
      end

      ST_CRC: begin
        data_in_ready     = mode_q;
        crc_bit_out_valid = ~mode_q;
        crc_bit_out       = ~mode_q & crc_bit;
        crc_xfer          = mode_q ? data_in_valid : crc_bit_out_ready;
        bit_mismatch      = mode_q & (data_in != crc_bit);
        if (abort) begin
          cnt_d    = '0;
          crc_ok_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (crc_xfer) begin
          if (cnt_q == CRC_LAST) begin
            done     = 1'b1;
            crc_ok_d = mode_q & ~(mismatch_q | bit_mismatch);
            cnt_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            mismatch_d = mismatch_q | bit_mismatch;
            cnt_d      = cnt_q + LEN_ONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      len_q       <= '0;
      init_q      <= '0;
      cnt_q       <= '0;
      mismatch_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_value_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      init_q      <= init_d;
      cnt_q       <= cnt_d;
      mismatch_q  <= mismatch_d;
      crc_ok_q    <= crc_ok_d;
      crc_value_q <= crc_value_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  // The verdict is visible in the same cycle as done, then held.
  assign crc_ok    = done ? crc_ok_d : crc_ok_q;
  assign crc_value = crc_value_q;
endmodule

// File: tb/tb_btle_crc24_seq.sv
// Self-checking bench for btle_crc24_seq: vector table, hand-written corner
// sequences and randomized packets against a polynomial-division CRC model.

module tb_btle_crc24_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [11:0] pdu_len_bits;
  logic [23:0] crc_state_init_bit;
  logic        abort;
  logic        data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic        crc_bit_out;
  logic        crc_bit_out_valid;
  logic        crc_bit_out_ready;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic [23:0] crc_value;

  btle_crc24_seq #(
    .CRC_STATE_BIT_WIDTH(24),
    .LEN_BIT_WIDTH      (12)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .mode               (mode),
    .pdu_len_bits       (pdu_len_bits),
    .crc_state_init_bit (crc_state_init_bit),
    .abort              (abort),
    .data_in            (data_in),
    .data_in_valid      (data_in_valid),
    .data_in_ready      (data_in_ready),
    .crc_bit_out        (crc_bit_out),
    .crc_bit_out_valid  (crc_bit_out_valid),
    .crc_bit_out_ready  (crc_bit_out_ready),
    .busy               (busy),
    .done               (done),
    .crc_ok             (crc_ok),
    .crc_value          (crc_value)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Packet stimulus and observed results.
  logic        pdu_bits [0:2055];
  logic [23:0] rx_crc;
  logic [23:0] tx_seq;
  int          tx_cnt;
  int          done_cnt;
  logic        done_ok;
  int          done_cyc;
  logic [23:0] snap;
  logic        busy_load;
  logic        busy_after;
  logic        ok_after;
  logic [29:0] outs_after;
  bit          timed_out;

  // Reference CRC as polynomial remainder:
  // (swap(init) * x^len + sum d_i * x^(23+len-i)) mod G.
  function automatic logic [23:0] crc_model(input int len, input logic [23:0] init);
    logic [23:0] g;
    logic [23:0] st;
    logic [23:0] r;
    bit          c [0:2100];
    g  = 24'h00065B;
    st = {init[7:0], init[15:8], init[23:16]};
    for (int i = 0; i <= 2100; i++) c[i] = 1'b0;
    for (int j = 0; j < 24; j++) c[j + len] = c[j + len] ^ st[j];
    for (int i = 0; i < len; i++) c[23 + len - i] = c[23 + len - i] ^ pdu_bits[i];
    for (int d = len + 23; d >= 24; d--) begin
      if (c[d]) begin
        c[d] = 1'b0;
        for (int j = 0; j < 24; j++) if (g[j]) c[d - 24 + j] = ~c[d - 24 + j];
      end
    end
    for (int j = 0; j < 24; j++) r[j] = c[j];
    return r;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    data_in_valid = 1'b0; data_in = 1'b0; crc_bit_out_ready = 1'b0;
  endtask

  // Drives one packet; abort_at / rst_at < 0 disable those events.
  task automatic run_packet(input bit m, input int len, input logic [23:0] init,
                            input int max_gap, input bit rnd_rdy, input int abort_at,
                            input bit inj_start, input int rst_at);
    int idx, gap, total, crc_k;
    bit injected, ended;
    @(posedge clk); #1;
    idle_inputs();
    start = 1'b1; mode = m; pdu_len_bits = 12'(len); crc_state_init_bit = init;
    @(negedge clk);
    idx = 0; gap = 0; total = len + (m ? 24 : 0);
    done_cnt = 0; tx_cnt = 0; tx_seq = '0; timed_out = 1'b1; injected = 1'b0;
    done_cyc = 1; ended = 1'b0;
    for (int c = 0; c < 5000 && !ended; c++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; rst = 1'b0; done_cyc++;
      if (gap > 0) begin
        data_in_valid = 1'b0; gap--;
      end else if (idx < total) begin
        data_in_valid = 1'b1;
        data_in = (idx < len) ? pdu_bits[idx] : rx_crc[23 - (idx - len)];
      end else begin
        data_in_valid = 1'($urandom % 2); data_in = 1'($urandom % 2);
      end
      crc_bit_out_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
      crc_k = m ? idx - len : tx_cnt;
      if (abort_at >= 0 && idx == abort_at && data_in_valid && c > 0) abort = 1'b1;
      if (inj_start && !injected && idx == 2) begin
        injected = 1'b1; start = 1'b1; mode = ~m; pdu_len_bits = 12'd3;
        crc_state_init_bit = ~init;
      end
      if (rst_at >= 0 && c > 0 && idx >= len && crc_k == rst_at) rst = 1'b1;
      @(negedge clk);
      if (c == 0) busy_load = busy;
      if (rst || abort) begin
        timed_out = 1'b0; ended = 1'b1;
      end else begin
        if (data_in_valid && data_in_ready) begin
          idx++;
          if (max_gap > 0) gap = $urandom_range(0, max_gap);
        end
        if (crc_bit_out_valid && crc_bit_out_ready && tx_cnt < 24) begin
          tx_seq[23 - tx_cnt] = crc_bit_out; tx_cnt++;
        end
        if (done) begin
          done_cnt++; done_ok = crc_ok; snap = crc_value;
          timed_out = 1'b0; ended = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    busy_after = busy; ok_after = crc_ok;
    if (done) done_cnt++;
    outs_after = {busy, done, crc_ok, data_in_ready, crc_bit_out_valid, crc_bit_out, crc_value};
    check("no_timeout", 64'(timed_out), 64'd0);
  endtask

  typedef struct {
    bit          mode;
    int          len;
    logic [23:0] init;
    logic [31:0] pattern;
    int          max_gap;
    bit          rnd_rdy;
    bit          flip;
    bit          exp_ok;
  } vec_t;

  vec_t        vecs [8];
  logic [23:0] exp_crc;
  bit          rmode, rflip;
  int          rlen, rgap;

  initial begin
    idle_inputs();
    mode = 1'b0; pdu_len_bits = '0; crc_state_init_bit = '0;
    rst = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {busy, done, crc_ok, data_in_ready, crc_bit_out_valid, crc_bit_out, crc_value}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Vector table: {mode, len, init, pattern, max_gap, rnd_rdy, flip_last, exp_ok}.
    vecs[0] = '{1'b0, 0,  24'h555555, 32'h0,        0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8,  24'h555555, 32'h0,        0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8,  24'h555555, 32'h0,        0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8,  24'h555555, 32'h0,        0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8,  24'h555555, 32'h0,        0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8,  24'h555555, 32'h0,        3, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 40, 24'h123456, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 0,  24'hABCDEF, 32'h0,        0, 1'b0, 1'b0, 1'b1};

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < vecs[v].len; i++) pdu_bits[i] = vecs[v].pattern[i % 32];
      exp_crc = crc_model(vecs[v].len, vecs[v].init);
      rx_crc  = exp_crc ^ {23'd0, vecs[v].flip};
      run_packet(vecs[v].mode, vecs[v].len, vecs[v].init, vecs[v].max_gap,
                 vecs[v].rnd_rdy, -1, 1'b0, -1);
      check($sformatf("vec%0d_crc_value", v), snap, exp_crc);
      check($sformatf("vec%0d_done_cnt", v), done_cnt, 1);
      check($sformatf("vec%0d_crc_ok", v), done_ok, vecs[v].exp_ok);
      check($sformatf("vec%0d_crc_ok_hold", v), ok_after, vecs[v].exp_ok);
      check($sformatf("vec%0d_busy_after_start", v), busy_load, 1);
      if (!vecs[v].mode) begin
        check($sformatf("vec%0d_tx_seq", v), tx_seq, exp_crc);
        check($sformatf("vec%0d_tx_cnt", v), tx_cnt, 24);
      end
      if (vecs[v].max_gap == 0 && !vecs[v].rnd_rdy)
        check($sformatf("vec%0d_duration", v), done_cyc, 26 + vecs[v].len);
      if (v == 0) begin
        check("len0_crc_const", snap, 24'h555555);
        check("len0_tx_alternating", tx_seq, 24'h555555);
      end
    end

    // Abort on the 5th DATA bit: no done, IDLE next cycle, crc_ok cleared.
    for (int i = 0; i < 16; i++) pdu_bits[i] = 1'($urandom % 2);
    run_packet(1'b0, 16, 24'h555555, 0, 1'b0, 4, 1'b0, -1);
    check("abort_busy_after", busy_after, 0);
    check("abort_no_done", done_cnt, 0);
    check("abort_crc_ok", ok_after, 0);

    // Fresh start after abort: LFSR holds byte-swapped init once LOAD is done.
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b0; pdu_len_bits = 12'd8; crc_state_init_bit = 24'h123456;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("load_cycle_not_ready", data_in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lfsr_after_load", dut.u_core.lfsr_q, 24'h563412);
    check("ready_two_cycles_after_start", data_in_ready, 1);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("abort2_idle", busy, 0);

    // start pulsed during DATA is ignored.
    for (int i = 0; i < 12; i++) pdu_bits[i] = 1'($urandom % 2);
    exp_crc = crc_model(12, 24'h0F0F0F);
    run_packet(1'b0, 12, 24'h0F0F0F, 0, 1'b0, -1, 1'b1, -1);
    check("inj_start_crc", snap, exp_crc);
    check("inj_start_tx_seq", tx_seq, exp_crc);
    check("inj_start_done_cnt", done_cnt, 1);

    // Synchronous reset in the middle of the RX CRC phase.
    for (int i = 0; i < 10; i++) pdu_bits[i] = 1'($urandom % 2);
    rx_crc = crc_model(10, 24'hC0FFEE);
    run_packet(1'b1, 10, 24'hC0FFEE, 0, 1'b0, -1, 1'b0, 5);
    check("rst_mid_crc_outputs", outs_after, 0);
    check("rst_mid_crc_no_done", done_cnt, 0);
    exp_crc = crc_model(10, 24'h00BEEF);
    run_packet(1'b0, 10, 24'h00BEEF, 0, 1'b0, -1, 1'b0, -1);
    check("after_rst_crc", snap, exp_crc);
    check("after_rst_tx_seq", tx_seq, exp_crc);

    // Maximum-length PDU.
    for (int i = 0; i < 2056; i++) pdu_bits[i] = 1'($urandom % 2);
    exp_crc = crc_model(2056, 24'h555555);
    rx_crc  = exp_crc;
    run_packet(1'b1, 2056, 24'h555555, 0, 1'b0, -1, 1'b0, -1);
    check("maxlen_crc", snap, exp_crc);
    check("maxlen_ok", done_ok, 1);

    // Randomized packets.
    for (int t = 0; t < 12; t++) begin
      rmode = 1'($urandom % 2);
      rlen  = $urandom_range(0, 100);
      rgap  = ($urandom % 2) ? 3 : 0;
      rflip = rmode & 1'($urandom % 2);
      crc_state_init_bit = $urandom;
      for (int i = 0; i < rlen; i++) pdu_bits[i] = 1'($urandom % 2);
      exp_crc = crc_model(rlen, crc_state_init_bit);
      rx_crc  = rflip ? (exp_crc ^ (24'd1 << $urandom_range(0, 23))) : exp_crc;
      run_packet(rmode, rlen, crc_state_init_bit, rgap, 1'($urandom % 2), -1, 1'b0, -1);
      check($sformatf("rnd%0d_crc", t), snap, exp_crc);
      check($sformatf("rnd%0d_done_cnt", t), done_cnt, 1);
      check($sformatf("rnd%0d_ok", t), done_ok, rmode & ~rflip);
      if (!rmode) check($sformatf("rnd%0d_tx_seq", t), tx_seq, exp_crc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
